// File: rtl/test_sink_checker_if.sv
// test_sink_checker_if: val/rdy stream carrying one message per transfer.
// master drives val/msg and observes rdy; slave (the sink) drives rdy.
interface test_sink_checker_if #(
  parameter int unsigned p_msg_nbits = 8
);
  logic                   in_val;
  logic                   in_rdy;
  logic [p_msg_nbits-1:0] in_msg;

  modport master (output in_val, output in_msg, input  in_rdy);
  modport slave  (input  in_val, input  in_msg, output in_rdy);
endinterface

// File: rtl/test_sink_checker.sv
// test_sink_checker: stream sink that compares each accepted message with a
// preloaded expected-message table, counts mismatches, captures the first
// failure and reports done/pass once the programmed count is consumed.
// Optional build macro TEST_SINK_RAND_RDY_EN: LFSR-driven backpressure on
// in_rdy (~25% stalls) to exercise upstream hold behaviour.
module test_sink_checker #(
  parameter int unsigned p_msg_nbits = 8,
  parameter int unsigned p_max_msgs  = 256,
  parameter logic [15:0] p_lfsr_seed = 16'hACE1,
  localparam int unsigned c_idx_nbits = $clog2(p_max_msgs)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_en,
  input  logic [c_idx_nbits-1:0] ld_addr,
  input  logic [p_msg_nbits-1:0] ld_data,
  input  logic [c_idx_nbits:0]   num_msgs,
  input  logic                   start,
  test_sink_checker_if.slave     in_if,
  output logic                   done,
  output logic                   pass,
  output logic [15:0]            err_count,
  output logic [c_idx_nbits-1:0] first_err_idx,
  output logic [p_msg_nbits-1:0] first_err_got
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  // first-mismatch capture record
  typedef struct packed {
    logic [c_idx_nbits-1:0] idx;
    logic [p_msg_nbits-1:0] got;
  } err_cap_t;

  localparam logic [c_idx_nbits:0]   CNT_MAX = (c_idx_nbits+1)'(p_max_msgs);
  localparam logic [c_idx_nbits:0]   CNT_ONE = (c_idx_nbits+1)'(1);
  localparam logic [c_idx_nbits-1:0] IDX_ONE = c_idx_nbits'(1);

  state_e                 state_q, state_d;
  logic [c_idx_nbits-1:0] idx_q;
  logic [c_idx_nbits-1:0] last_q;
  logic                   armed_q;
  err_cap_t               cap_q;
  logic [p_msg_nbits-1:0] tbl [p_max_msgs];

  logic [c_idx_nbits:0]   cnt_clamp;
  logic [c_idx_nbits:0]   cnt_m1;
  logic                   restart;
  logic                   xfer;
  logic                   miss;

  // count clamped to the table depth; last index derived once at start
  assign cnt_clamp = (num_msgs > CNT_MAX) ? CNT_MAX : num_msgs;
  assign cnt_m1    = cnt_clamp - CNT_ONE;
  assign restart   = start && (state_q != S_RUN);
  assign xfer      = (state_q == S_RUN) && in_if.in_val && in_if.in_rdy;
  assign miss      = (in_if.in_msg != tbl[idx_q]);

`ifdef TEST_SINK_RAND_RDY_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Fibonacci LFSR (taps 16,14,13,11), advances only while running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                lfsr_q <= p_lfsr_seed;
    else if (state_q == S_RUN) lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  assign in_if.in_rdy = (state_q == S_RUN) && (lfsr_q[1:0] != 2'b00);
`else
  assign in_if.in_rdy = (state_q == S_RUN);
`endif

  // expected-message table; no reset, contents undefined after reset
  always_ff @(posedge clk) begin
    if (ld_en && (state_q != S_RUN)) tbl[ld_addr] <= ld_data;
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state: start honoured outside RUN, final transfer ends the run
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (cnt_clamp == '0) ? S_DONE : S_RUN;
      S_RUN:          if (xfer && (idx_q == last_q)) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // index, mismatch counter and first-error capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q     <= '0;
      last_q    <= '0;
      armed_q   <= 1'b0;
      cap_q     <= '0;
      err_count <= '0;
    end else if (restart) begin
      idx_q     <= '0;
      last_q    <= cnt_m1[c_idx_nbits-1:0];
      armed_q   <= 1'b1;
      cap_q     <= '0;
      err_count <= '0;
    end else if (xfer) begin
      idx_q <= idx_q + IDX_ONE;
      if (miss) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (armed_q) begin
          cap_q   <= '{idx: idx_q, got: in_if.in_msg};
          armed_q <= 1'b0;
        end
      end
    end
  end

  assign done          = (state_q == S_DONE);
  assign pass          = done && (err_count == '0);
  assign first_err_idx = cap_q.idx;
  assign first_err_got = cap_q.got;

endmodule

// File: tb/tb_test_sink_checker.sv
// tb_test_sink_checker: directed vector table plus hand sequences for the
// multi-cycle cases (DONE hold, mid-run reset, ignored RUN controls, long run).
module tb_test_sink_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [8:0]  num_msgs;
  logic        start;
  logic        done, pass;
  logic [15:0] err_count;
  logic [7:0]  first_err_idx, first_err_got;

  int n_chk = 0;
  int n_err = 0;

  test_sink_checker_if #(.p_msg_nbits(8)) bus ();

  test_sink_checker dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .num_msgs(num_msgs), .start(start), .in_if(bus), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx), .first_err_got(first_err_got)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [8:0] num;
    logic       val;
    logic [7:0] msg;
    logic       e_rdy, e_done, e_pass;
    int         e_err, e_fidx, e_fgot;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input int d);
    ld_en = 1'b1; ld_addr = 8'(a); ld_data = 8'(d);
    tick();
    ld_en = 1'b0;
  endtask

  task automatic load4();
    load(0, 8'h11); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44);
  endtask

  task automatic go(input int n);
    start = 1'b1; num_msgs = 9'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic xfer(input int m);
    bus.in_val = 1'b1; bus.in_msg = 8'(m);
    tick();
    bus.in_val = 1'b0;
  endtask

  initial begin
    int sent, stalls, cyc;
    logic [7:0] exp_tbl [256];
    logic v, r;

    reset = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    num_msgs = '0; start = 1'b0; bus.in_val = 1'b0; bus.in_msg = '0;

    //               start num  val msg    rdy done pass err fidx fgot
    vecs[0]  = '{1'b1, 9'd4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vecs[1]  = '{1'b0, 9'd4, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vecs[2]  = '{1'b0, 9'd4, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vecs[3]  = '{1'b0, 9'd4, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vecs[4]  = '{1'b0, 9'd4, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 0, 0, 0};
    vecs[5]  = '{1'b1, 9'd4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vecs[6]  = '{1'b0, 9'd4, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vecs[7]  = '{1'b0, 9'd4, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vecs[8]  = '{1'b0, 9'd4, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1, 2, 8'h55};
    vecs[9]  = '{1'b0, 9'd4, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1, 2, 8'h55};
    vecs[10] = '{1'b1, 9'd0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 0, 0, 0};
    vecs[11] = '{1'b0, 9'd0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 0, 0, 0};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",  int'(bus.in_rdy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err",  int'(err_count), 0);
    chk("rst_fidx", int'(first_err_idx), 0);
    chk("rst_fgot", int'(first_err_got), 0);
    reset = 1'b1;
    tick();

`ifndef TEST_SINK_RAND_RDY_EN
    // cycle-exact checks below assume full-rate ready
    load4();
    foreach (vecs[i]) begin
      start = vecs[i].start; num_msgs = vecs[i].num;
      bus.in_val = vecs[i].val; bus.in_msg = vecs[i].msg;
      tick();
      start = 1'b0;
      chk($sformatf("v%0d_rdy", i),  int'(bus.in_rdy), int'(vecs[i].e_rdy));
      chk($sformatf("v%0d_done", i), int'(done), int'(vecs[i].e_done));
      chk($sformatf("v%0d_pass", i), int'(pass), int'(vecs[i].e_pass));
      chk($sformatf("v%0d_err", i),  int'(err_count), vecs[i].e_err);
      chk($sformatf("v%0d_fidx", i), int'(first_err_idx), vecs[i].e_fidx);
      chk($sformatf("v%0d_fgot", i), int'(first_err_got), vecs[i].e_fgot);
    end
    bus.in_val = 1'b0;

    // DONE holds with upstream valid asserted, then restart clears
    go(4); xfer(8'h11); xfer(8'h22); xfer(8'h55); xfer(8'h44);
    bus.in_val = 1'b1; bus.in_msg = 8'h11;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_rdy",  int'(bus.in_rdy), 0);
      chk("hold_done", int'(done), 1);
      chk("hold_err",  int'(err_count), 1);
      chk("hold_fidx", int'(first_err_idx), 2);
    end
    bus.in_val = 1'b0;
    go(4);
    chk("rs_err",  int'(err_count), 0);
    chk("rs_fidx", int'(first_err_idx), 0);
    chk("rs_done", int'(done), 0);
    chk("rs_rdy",  int'(bus.in_rdy), 1);
    xfer(8'h11); xfer(8'h22); xfer(8'h33); xfer(8'h44);
    chk("rs_pass", int'(pass), 1);

    // load+start together from DONE; load/start during RUN are ignored
    ld_en = 1'b1; ld_addr = 8'd0; ld_data = 8'hA0;
    go(2);
    ld_en = 1'b1; ld_addr = 8'd1; ld_data = 8'hFF; start = 1'b1; num_msgs = 9'd4;
    xfer(8'hA0);
    ld_en = 1'b0; start = 1'b0;
    xfer(8'h22);
    chk("ign_done", int'(done), 1);
    chk("ign_pass", int'(pass), 1);
    chk("ign_err",  int'(err_count), 0);

    // reset mid-run after 2 of 4 transfers (one a mismatch)
    load4();
    go(4); xfer(8'h11); xfer(8'h99);
    chk("mr_err_pre", int'(err_count), 1);
    reset = 1'b0;
    #1;
    chk("mr_rdy",  int'(bus.in_rdy), 0);
    chk("mr_done", int'(done), 0);
    chk("mr_err",  int'(err_count), 0);
    chk("mr_fgot", int'(first_err_got), 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    load4();
    go(4); xfer(8'h11); xfer(8'h22); xfer(8'h33); xfer(8'h44);
    chk("mr2_done", int'(done), 1);
    chk("mr2_pass", int'(pass), 1);
`endif

    // long run, count 300 clamps to 256, random upstream gaps
    for (int i = 0; i < 256; i++) begin
      exp_tbl[i] = 8'(i) ^ 8'h5A;
      load(i, int'(exp_tbl[i]));
    end
    go(300);
    sent = 0; stalls = 0; cyc = 0;
    while (!done && cyc < 4000) begin
      v = ($urandom_range(0, 3) != 0);
      r = bus.in_rdy;
      bus.in_val = v;
      bus.in_msg = v ? exp_tbl[sent[7:0]] : 8'($urandom);
      if (!r) stalls++;
      tick();
      if (v && r) sent++;
      cyc++;
    end
    bus.in_val = 1'b0;
    chk("long_done", int'(done), 1);
    chk("long_sent", sent, 256);
    chk("long_pass", int'(pass), 1);
    chk("long_err",  int'(err_count), 0);
`ifdef TEST_SINK_RAND_RDY_EN
    chk("long_stall_seen", int'(stalls > 0), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
